regfile_2r1w: RTL and testbench

Parametrised register file with two independent registered read ports, one write port, optional write-to-read bypass, optional hardwired zero register, and a per-register busy scoreboard. It is the successor to the single-port 16x8 register file. It sits between decode (reads, busy set on issue) and write-back (write, busy clear) in the MZNM pipeline. All storage and read data update on the rising clock edge, which removes the mixed-edge scheme used previously.

---
 rtl/regfile_2r1w.sv | 100 ++++++++++
 tb/tb_regfile_2r1w.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered read ports, optional
// write-to-read forwarding, optional hardwired zero register and a busy scoreboard.
module regfile_2r1w #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0,
  localparam int DEPTH   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en0,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [DATA_W-1:0] rd_data0,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              busy0,
  output logic              busy1,
  output logic [DEPTH-1:0]  busy_vec
);

  // No handshake: every enabled read, write and busy mark is taken on each
  // rising edge; there is no backpressure and no stall.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data0_q, rd_data0_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr_ok;

  // A write to the hardwired zero register is silently dropped.
  assign wr_ok = wr_en && !(ZERO_REG && (wr_addr == '0));

  always_comb begin
    rd_data0_d = rd_data0_q;
    if (rd_en0) begin
      if (ZERO_REG && (rd_addr0 == '0))
        rd_data0_d = '0;
      else if (BYPASS && wr_ok && (wr_addr == rd_addr0))
        rd_data0_d = wr_data;
      else
        rd_data0_d = mem_q[rd_addr0];
    end
  end

  always_comb begin
    rd_data1_d = rd_data1_q;
    if (rd_en1) begin
      if (ZERO_REG && (rd_addr1 == '0))
        rd_data1_d = '0;
      else if (BYPASS && wr_ok && (wr_addr == rd_addr1))
        rd_data1_d = wr_data;
      else
        rd_data1_d = mem_q[rd_addr1];
    end
  end

  // Set beats clear on the same bit: a newly issued producer supersedes the write-back.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_set && (busy_addr == ADDR_W'(i)) && !(ZERO_REG && (i == 0)))
        busy_d[i] = 1'b1;
      else if (wr_en && (wr_addr == ADDR_W'(i)))
        busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data0_q <= '0;
      rd_data1_q <= '0;
      busy_q     <= '0;
    end else begin
      rd_data0_q <= rd_data0_d;
      rd_data1_q <= rd_data1_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_data0 = rd_data0_q;
  assign rd_data1 = rd_data1_q;
  assign busy_vec = busy_q;
  assign busy0    = busy_q[rd_addr0];
  assign busy1    = busy_q[rd_addr1];

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: one instance with forwarding and no zero register,
// one without forwarding and with the zero register, driven from shared inputs.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic        rd_en0, rd_en1, wr_en, busy_set;
  logic [2:0]  rd_addr0, rd_addr1, wr_addr, busy_addr;
  logic [15:0] wr_data;
  logic [15:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic        a_b0, a_b1, b_b0, b_b1;
  logic [7:0]  a_bv, b_bv;

  int n_total = 0;
  int n_pass  = 0;

  regfile_2r1w u_a (
    .clk(clk), .rst(rst),
    .rd_en0(rd_en0), .rd_addr0(rd_addr0), .rd_data0(a_rd0),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(a_rd1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .busy0(a_b0), .busy1(a_b1), .busy_vec(a_bv)
  );

  regfile_2r1w #(.BYPASS(1'b0), .ZERO_REG(1'b1)) u_b (
    .clk(clk), .rst(rst),
    .rd_en0(rd_en0), .rd_addr0(rd_addr0), .rd_data0(b_rd0),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(b_rd1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_addr(busy_addr),
    .busy0(b_b0), .busy1(b_b1), .busy_vec(b_bv)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        re0;
    logic [2:0]  ra0;
    logic        re1;
    logic [2:0]  ra1;
    logic        bs;
    logic [2:0]  ba;
    logic [15:0] e0a, e1a;
    logic [7:0]  eva;
    logic [15:0] e0b, e1b;
    logic [7:0]  evb;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
    input logic we, input logic [2:0] wa, input logic [15:0] wd,
    input logic re0, input logic [2:0] ra0, input logic re1, input logic [2:0] ra1,
    input logic bs, input logic [2:0] ba,
    input logic [15:0] e0a, input logic [15:0] e1a, input logic [7:0] eva,
    input logic [15:0] e0b, input logic [15:0] e1b, input logic [7:0] evb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.re0 = re0; v.ra0 = ra0; v.re1 = re1; v.ra1 = ra1;
    v.bs = bs; v.ba = ba;
    v.e0a = e0a; v.e1a = e1a; v.eva = eva;
    v.e0b = e0b; v.e1b = e1b; v.evb = evb;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic re0, input logic [2:0] ra0,
                       input logic re1, input logic [2:0] ra1,
                       input logic bs, input logic [2:0] ba);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en0 = re0; rd_addr0 = ra0; rd_en1 = re1; rd_addr1 = ra1;
    busy_set = bs; busy_addr = ba;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk_all(input string tag,
                         input logic [15:0] e0a, input logic [15:0] e1a, input logic [7:0] eva,
                         input logic [15:0] e0b, input logic [15:0] e1b, input logic [7:0] evb);
    chk({tag, " a rd0"}, a_rd0, e0a);
    chk({tag, " a rd1"}, a_rd1, e1a);
    chk({tag, " a busy_vec"}, {8'h00, a_bv}, {8'h00, eva});
    chk({tag, " a busy0"}, {15'h0, a_b0}, {15'h0, eva[rd_addr0]});
    chk({tag, " a busy1"}, {15'h0, a_b1}, {15'h0, eva[rd_addr1]});
    chk({tag, " b rd0"}, b_rd0, e0b);
    chk({tag, " b rd1"}, b_rd1, e1b);
    chk({tag, " b busy_vec"}, {8'h00, b_bv}, {8'h00, evb});
    chk({tag, " b busy0"}, {15'h0, b_b0}, {15'h0, evb[rd_addr0]});
    chk({tag, " b busy1"}, {15'h0, b_b1}, {15'h0, evb[rd_addr1]});
  endtask

  initial begin
    // Vectors applied after the reset sequence; all state is zero at that point.
    tbl[0]  = mk(1,1,16'h1111, 0,0,0,0, 0,0, 16'h0000,16'h0000,8'h00, 16'h0000,16'h0000,8'h00);
    tbl[1]  = mk(1,6,16'h6666, 0,0,0,0, 0,0, 16'h0000,16'h0000,8'h00, 16'h0000,16'h0000,8'h00);
    tbl[2]  = mk(0,0,16'h0000, 1,1,1,6, 0,0, 16'h1111,16'h6666,8'h00, 16'h1111,16'h6666,8'h00);
    tbl[3]  = mk(0,0,16'h0000, 0,6,0,6, 0,0, 16'h1111,16'h6666,8'h00, 16'h1111,16'h6666,8'h00);
    tbl[4]  = mk(1,2,16'h0022, 0,6,0,6, 0,0, 16'h1111,16'h6666,8'h00, 16'h1111,16'h6666,8'h00);
    tbl[5]  = mk(1,2,16'hABCD, 1,2,0,6, 0,0, 16'hABCD,16'h6666,8'h00, 16'h0022,16'h6666,8'h00);
    tbl[6]  = mk(0,0,16'h0000, 1,2,1,2, 0,0, 16'hABCD,16'hABCD,8'h00, 16'hABCD,16'hABCD,8'h00);
    tbl[7]  = mk(1,0,16'hFFFF, 0,0,0,0, 1,0, 16'hABCD,16'hABCD,8'h01, 16'hABCD,16'hABCD,8'h00);
    tbl[8]  = mk(0,0,16'h0000, 1,0,1,0, 0,0, 16'hFFFF,16'hFFFF,8'h01, 16'h0000,16'h0000,8'h00);
    tbl[9]  = mk(0,0,16'h0000, 0,5,0,0, 1,5, 16'hFFFF,16'hFFFF,8'h21, 16'h0000,16'h0000,8'h20);
    tbl[10] = mk(1,5,16'h5555, 0,5,0,0, 1,5, 16'hFFFF,16'hFFFF,8'h21, 16'h0000,16'h0000,8'h20);
    tbl[11] = mk(1,5,16'h5A5A, 0,5,0,0, 0,0, 16'hFFFF,16'hFFFF,8'h01, 16'h0000,16'h0000,8'h00);
    tbl[12] = mk(1,0,16'h1234, 1,5,0,0, 0,0, 16'h5A5A,16'hFFFF,8'h00, 16'h5A5A,16'h0000,8'h00);
    tbl[13] = mk(1,0,16'h9999, 0,5,1,0, 0,0, 16'h5A5A,16'h9999,8'h00, 16'h5A5A,16'h0000,8'h00);
    tbl[14] = mk(1,6,16'h0606, 1,6,1,7, 1,7, 16'h0606,16'h0000,8'h80, 16'h6666,16'h0000,8'h80);
    tbl[15] = mk(1,7,16'h7777, 1,6,1,7, 1,6, 16'h0606,16'h7777,8'h40, 16'h0606,16'h0000,8'h40);

    rst = 1'b0;
    drive(0,0,16'h0000, 0,0,0,0, 0,0);
    tick();
    tick();
    chk_all("reset", 16'h0, 16'h0, 8'h00, 16'h0, 16'h0, 8'h00);
    rst = 1'b1;
    tick();

    // Load r3 and mark it busy, then reset asynchronously mid-cycle.
    drive(1,3,16'hBEEF, 1,3,0,0, 1,3);
    tick();
    chk_all("pre-rst wr", 16'hBEEF, 16'h0, 8'h08, 16'h0000, 16'h0, 8'h08);
    drive(0,0,16'h0000, 1,3,1,3, 0,0);
    tick();
    chk_all("pre-rst rd", 16'hBEEF, 16'hBEEF, 8'h08, 16'hBEEF, 16'hBEEF, 8'h08);
    drive(0,0,16'h0000, 0,3,0,3, 0,0);
    #2 rst = 1'b0;
    #1 chk_all("async rst", 16'h0, 16'h0, 8'h00, 16'h0, 16'h0, 8'h00);
    #1 rst = 1'b1;
    drive(0,0,16'h0000, 1,3,1,3, 0,0);
    tick();
    chk_all("post-rst r3", 16'h0, 16'h0, 8'h00, 16'h0, 16'h0, 8'h00);

    for (int r = 0; r < 16; r++) begin
      drive(tbl[r].we, tbl[r].wa, tbl[r].wd, tbl[r].re0, tbl[r].ra0,
            tbl[r].re1, tbl[r].ra1, tbl[r].bs, tbl[r].ba);
      tick();
      chk_all($sformatf("row%0d", r), tbl[r].e0a, tbl[r].e1a, tbl[r].eva,
              tbl[r].e0b, tbl[r].e1b, tbl[r].evb);
    end

    // Back-to-back writes r0..r7 with port 1 reading one cycle behind.
    for (int i = 0; i <= 8; i++) begin
      logic [15:0] exp_a, exp_b;
      drive((i < 8), 3'(i), 16'h0100 + 16'(i), 0, 0, (i >= 1), 3'(i - 1), 0, 0);
      tick();
      if (i >= 1) begin
        exp_a = 16'h0100 + 16'(i - 1);
        exp_b = (i == 1) ? 16'h0000 : exp_a;
        chk($sformatf("b2b r%0d a", i - 1), a_rd1, exp_a);
        chk($sformatf("b2b r%0d b", i - 1), b_rd1, exp_b);
      end
    end
    chk("b2b a busy_vec", {8'h00, a_bv}, 16'h0000);
    chk("b2b b busy_vec", {8'h00, b_bv}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
